// File: rtl/multicycle_ctrl.sv
// ----------------------------------------------------------------------------
// multicycle_ctrl
//
// Control FSM for a multicycle datapath. Sequences each instruction through
// fetch, decode, execute, memory and write-back. It also keeps a count of
// retired instructions, a halt flag and a sticky illegal-opcode flag. No data
// passes through this block. It only reads the decoded opcode and the ALU
// equality flag.
//
// Ports
//   clk          system clock, all state on rising edge
//   rst_n        asynchronous active-low reset
//   run          1 = keep fetching; 0 = finish current instruction, then idle
//   opcode       decoded opcode from the instruction decoder
//   alu_zero     ALU equality flag, consulted in BRANCH
//   sel_ins      IorD select (0 = PC)
//   ir_write     instruction-register load enable
//   pc_write     PC load enable
//   pc_src       PC mux: 00 PC+1, 01 ALU, 10 jump addr, 11 latched ALUout
//   alu_src_a    ALU A mux: 0 = PC, 1 = reg A
//   alu_src_b    ALU B mux: 00 reg B, 01 const 1, 10 sign-extended imm
//   reg_write    register-file write enable
//   reg_dst      write register: 0 = Rt, 1 = Rd
//   mem_to_reg   write-back source: 0 = ALU, 1 = DMem
//   mem_write    data-memory write enable
//   beq_sel      0 = branch on equal, 1 = branch on not-equal
//   state        current state encoding (debug)
//   instr_count  retired-instruction counter, wraps
//   halted       FSM parked in HALT
//   illegal      sticky undefined-opcode flag
// ----------------------------------------------------------------------------
module multicycle_ctrl #(
   parameter int          CNT_W   = 16,
   parameter logic [5:0]  HALT_OP = 6'b111111
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             run,
   input  logic [5:0]       opcode,
   input  logic             alu_zero,
   output logic             sel_ins,
   output logic             ir_write,
   output logic             pc_write,
   output logic [1:0]       pc_src,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic             reg_write,
   output logic             reg_dst,
   output logic             mem_to_reg,
   output logic             mem_write,
   output logic             beq_sel,
   output logic [3:0]       state,
   output logic [CNT_W-1:0] instr_count,
   output logic             halted,
   output logic             illegal
);

   typedef enum logic [3:0] {
      S_IDLE   = 4'd0,
      S_FETCH  = 4'd1,
      S_DECODE = 4'd2,
      S_EXEC_R = 4'd3,
      S_WB_R   = 4'd4,
      S_EXEC_I = 4'd5,
      S_WB_I   = 4'd6,
      S_MEM_RD = 4'd7,
      S_LW_WB  = 4'd8,
      S_MEM_WR = 4'd9,
      S_BRANCH = 4'd10,
      S_JUMP   = 4'd11,
      S_HALT   = 4'd12
   } state_t;

   typedef enum logic [2:0] {
      OP_R, OP_I, OP_LW, OP_SW, OP_BR, OP_J, OP_HALT, OP_ILL
   } op_class_t;

   state_t     cur_state;
   state_t     nxt_state;
   op_class_t  op_class;
   logic       retire;
   logic       set_illegal;

   // Opcode classification. HALT_OP is tested first so a parameter override
   // that lands inside another class still parks the FSM.
   always_comb begin
      if (opcode == HALT_OP)            op_class = OP_HALT;
      else if (opcode[5:4] == 2'b00)    op_class = OP_R;
      else if (opcode[5:4] == 2'b01)    op_class = OP_I;
      else begin
         case (opcode)
            6'b100001: op_class = OP_LW;
            6'b100010: op_class = OP_SW;
            6'b110000,
            6'b110001: op_class = OP_BR;
            6'b111000: op_class = OP_J;
            default:   op_class = OP_ILL;
         endcase
      end
   end

   // NOTE: every output of this block gets a default before the case, so no
   // path through it can leave a signal unassigned and infer a latch.
   always_comb begin
      nxt_state   = cur_state;
      retire      = 1'b0;
      set_illegal = 1'b0;
      sel_ins     = 1'b0;
      ir_write    = 1'b0;
      pc_write    = 1'b0;
      pc_src      = 2'b00;
      alu_src_a   = 1'b0;
      alu_src_b   = 2'b00;
      reg_write   = 1'b0;
      reg_dst     = 1'b0;
      mem_to_reg  = 1'b0;
      mem_write   = 1'b0;
      beq_sel     = 1'b0;

      case (cur_state)
         S_IDLE: begin
            if (run) nxt_state = S_FETCH;
         end
         S_FETCH: begin
            ir_write  = 1'b1;
            alu_src_b = 2'b01;
            pc_write  = 1'b1;
            nxt_state = S_DECODE;
         end
         S_DECODE: begin
            // PC+imm is computed here so BRANCH can load it from ALUout.
            alu_src_b = 2'b10;
            case (op_class)
               OP_R:    nxt_state = S_EXEC_R;
               OP_I:    nxt_state = S_EXEC_I;
               OP_LW:   nxt_state = S_MEM_RD;
               OP_SW:   nxt_state = S_MEM_WR;
               OP_BR:   nxt_state = S_BRANCH;
               OP_J:    nxt_state = S_JUMP;
               OP_HALT: nxt_state = S_HALT;
               default: begin
                  set_illegal = 1'b1;
                  nxt_state   = run ? S_FETCH : S_IDLE;
               end
            endcase
         end
         S_EXEC_R: begin
            alu_src_a = 1'b1;
            nxt_state = S_WB_R;
         end
         S_WB_R: begin
            reg_dst   = 1'b1;
            reg_write = 1'b1;
            retire    = 1'b1;
         end
         S_EXEC_I: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            nxt_state = S_WB_I;
         end
         S_WB_I: begin
            reg_write = 1'b1;
            retire    = 1'b1;
         end
         S_MEM_RD: begin
            nxt_state = S_LW_WB;
         end
         S_LW_WB: begin
            mem_to_reg = 1'b1;
            reg_write  = 1'b1;
            retire     = 1'b1;
         end
         S_MEM_WR: begin
            mem_write = 1'b1;
            retire    = 1'b1;
         end
         S_BRANCH: begin
            alu_src_a = 1'b1;
            beq_sel   = opcode[0];
            pc_src    = 2'b11;
            // The only Mealy output: taken/not-taken follows alu_zero live.
            pc_write  = alu_zero ^ opcode[0];
            retire    = 1'b1;
         end
         S_JUMP: begin
            pc_src    = 2'b10;
            pc_write  = 1'b1;
            retire    = 1'b1;
         end
         S_HALT: begin
            nxt_state = S_HALT;
         end
         default: nxt_state = S_IDLE;
      endcase

      if (retire) nxt_state = run ? S_FETCH : S_IDLE;
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values, independent of block evaluation order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur_state   <= S_IDLE;
         instr_count <= '0;
         illegal     <= 1'b0;
      end else begin
         cur_state <= nxt_state;
         if (retire)      instr_count <= instr_count + CNT_W'(1);
         if (set_illegal) illegal     <= 1'b1;
      end
   end

   assign state  = cur_state;
   assign halted = (cur_state == S_HALT);

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;
   localparam int CNT_W = 16;
   localparam logic [5:0] HALT_OP = 6'b111111;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             run = 1'b0;
   logic [5:0]       opcode = 6'd0;
   logic             alu_zero = 1'b0;
   logic             sel_ins, ir_write, pc_write, alu_src_a;
   logic [1:0]       pc_src, alu_src_b;
   logic             reg_write, reg_dst, mem_to_reg, mem_write, beq_sel;
   logic [3:0]       state;
   logic [CNT_W-1:0] instr_count;
   logic             halted, illegal;

   always #5 clk = ~clk;

   multicycle_ctrl #(.CNT_W(CNT_W), .HALT_OP(HALT_OP)) dut (
      .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .alu_zero(alu_zero),
      .sel_ins(sel_ins), .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .reg_write(reg_write),
      .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .mem_write(mem_write),
      .beq_sel(beq_sel), .state(state), .instr_count(instr_count),
      .halted(halted), .illegal(illegal)
   );

   typedef struct packed {
      logic       sel_ins;
      logic       ir_write;
      logic       pc_write;
      logic [1:0] pc_src;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic       reg_write;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       mem_write;
      logic       beq_sel;
   } ctl_t;

   ctl_t dut_ctl;
   always_comb dut_ctl = {sel_ins, ir_write, pc_write, pc_src, alu_src_a, alu_src_b,
                          reg_write, reg_dst, mem_to_reg, mem_write, beq_sel};

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // An instruction is a list of state codes; the model walks a position
   // through that list and applies retire/illegal/halt at the end of it.
   localparam int C_R = 0, C_I = 1, C_LW = 2, C_SW = 3, C_BR = 4, C_J = 5,
                  C_HALT = 6, C_ILL = 7;

   function automatic int classify(input logic [5:0] op);
      if (op == HALT_OP)            return C_HALT;
      if (op[5:4] == 2'b00)         return C_R;
      if (op[5:4] == 2'b01)         return C_I;
      if (op == 6'b100001)          return C_LW;
      if (op == 6'b100010)          return C_SW;
      if (op == 6'b110000 || op == 6'b110001) return C_BR;
      if (op == 6'b111000)          return C_J;
      return C_ILL;
   endfunction

   function automatic int cls_len(input int c);
      return (c == C_R || c == C_I || c == C_LW) ? 4 : 3;
   endfunction

   function automatic logic [3:0] cls_code(input int c, input int pos);
      case (c)
         C_R:     return (pos == 2) ? 4'd3 : 4'd4;
         C_I:     return (pos == 2) ? 4'd5 : 4'd6;
         C_LW:    return (pos == 2) ? 4'd7 : 4'd8;
         C_SW:    return 4'd9;
         C_BR:    return 4'd10;
         default: return 4'd11;
      endcase
   endfunction

   int               m_mode;   // 0 idle, 1 busy, 2 halted
   int               m_pos;
   int               m_cls;
   logic [CNT_W-1:0] m_count;
   logic             m_ill;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_mode <= 0; m_pos <= 0; m_cls <= 0; m_count <= '0; m_ill <= 1'b0;
      end else begin
         case (m_mode)
            0: if (run) begin m_mode <= 1; m_pos <= 0; end
            1: begin
               if (m_pos == 0) m_pos <= 1;
               else if (m_pos == 1) begin
                  m_cls <= classify(opcode);
                  if (classify(opcode) == C_ILL) begin
                     m_ill <= 1'b1; m_mode <= run ? 1 : 0; m_pos <= 0;
                  end else if (classify(opcode) == C_HALT) m_mode <= 2;
                  else m_pos <= 2;
               end else if (m_pos + 1 == cls_len(m_cls)) begin
                  m_count <= m_count + CNT_W'(1);
                  m_mode  <= run ? 1 : 0;
                  m_pos   <= 0;
               end else m_pos <= m_pos + 1;
            end
            default: ;
         endcase
      end
   end

   function automatic logic [3:0] exp_state();
      if (m_mode == 0) return 4'd0;
      if (m_mode == 2) return 4'd12;
      if (m_pos == 0)  return 4'd1;
      if (m_pos == 1)  return 4'd2;
      return cls_code(m_cls, m_pos);
   endfunction

   function automatic ctl_t exp_ctl(input logic [3:0] s, input logic [5:0] op, input logic az);
      ctl_t c;
      c = '0;
      case (s)
         4'd1:  begin c.ir_write = 1; c.alu_src_b = 2'b01; c.pc_write = 1; end
         4'd2:  c.alu_src_b = 2'b10;
         4'd3:  c.alu_src_a = 1;
         4'd4:  begin c.reg_dst = 1; c.reg_write = 1; end
         4'd5:  begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
         4'd6:  c.reg_write = 1;
         4'd8:  begin c.mem_to_reg = 1; c.reg_write = 1; end
         4'd9:  c.mem_write = 1;
         4'd10: begin c.alu_src_a = 1; c.beq_sel = op[0]; c.pc_src = 2'b11;
                      c.pc_write = az ^ op[0]; end
         4'd11: begin c.pc_src = 2'b10; c.pc_write = 1; end
         default: ;
      endcase
      return c;
   endfunction

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      check("state",   32'(state),       32'(exp_state()));
      check("ctl",     32'(dut_ctl),     32'(exp_ctl(exp_state(), opcode, alu_zero)));
      check("count",   32'(instr_count), 32'(m_count));
      check("halted",  32'(halted),      32'(m_mode == 2));
      check("illegal", 32'(illegal),     32'(m_ill));
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int r;
      int halt_cycles;

      // Reset state
      #2;
      check("rst_state",   32'(state), 32'd0);
      check("rst_ctl",     32'(dut_ctl), 32'd0);
      check("rst_count",   32'(instr_count), 32'd0);
      check("rst_flags",   32'({halted, illegal}), 32'd0);
      #10;
      rst_n = 1'b1; run = 1'b1; opcode = 6'b000010;

      // R-type held: 1,2,3,4 repeating
      for (int i = 0; i < 12; i++) begin
         tick();
         check("r_seq", 32'(state), 32'((i % 4) + 1));
         if (i % 4 == 3) check("r_wb", 32'({reg_write, reg_dst}), 32'b11);
         else            check("r_nowb", 32'(reg_write), 32'd0);
      end
      tick();
      check("r_count3", 32'(instr_count), 32'd3);

      // LW then SW
      opcode = 6'b100001;
      tick(); tick();
      check("lw_memrd", 32'(state), 32'd7);
      check("lw_memrd_wb", 32'({mem_to_reg, reg_write}), 32'b00);
      tick();
      check("lw_wb", 32'({state, mem_to_reg, reg_write}), 32'({4'd8, 2'b11}));
      opcode = 6'b100010;
      tick(); tick(); tick();
      check("sw_wr", 32'({state, mem_write}), 32'({4'd9, 1'b1}));
      tick();
      check("lwsw_count", 32'(instr_count), 32'd5);
      check("lwsw_nowr", 32'(mem_write), 32'd0);

      // BEQ taken, BNE not taken with alu_zero=1
      opcode = 6'b110000; alu_zero = 1'b1;
      tick(); tick();
      check("beq", 32'({state, pc_src, pc_write, beq_sel}), 32'({4'd10, 2'b11, 1'b1, 1'b0}));
      tick();
      opcode = 6'b110001;
      tick(); tick();
      check("bne", 32'({state, pc_src, pc_write, beq_sel}), 32'({4'd10, 2'b11, 1'b0, 1'b1}));
      tick();
      check("br_count", 32'(instr_count), 32'd7);

      // Jump, then run low during JUMP
      opcode = 6'b111000;
      tick(); tick();
      check("jump", 32'({state, pc_src, pc_write}), 32'({4'd11, 2'b10, 1'b1}));
      run = 1'b0;
      tick();
      check("j_idle", 32'({state, dut_ctl}), 32'd0);
      check("j_count", 32'(instr_count), 32'd8);
      tick();
      check("j_idle2", 32'(state), 32'd0);
      run = 1'b1;
      tick();
      check("j_refetch", 32'(state), 32'd1);

      // Illegal opcode
      opcode = 6'b101111;
      tick(); tick();
      check("ill_flag", 32'({illegal, state}), 32'({1'b1, 4'd1}));
      check("ill_count", 32'(instr_count), 32'd8);

      // Async reset in WB_R
      opcode = 6'b000010;
      tick(); tick(); tick();
      check("pre_rst_wb", 32'({state, reg_write}), 32'({4'd4, 1'b1}));
      #3 rst_n = 1'b0;
      #1;
      check("arst_state", 32'({state, reg_write}), 32'd0);
      check("arst_regs", 32'({instr_count, illegal, halted}), 32'd0);
      #2 rst_n = 1'b1;

      // HALT held for 20 cycles regardless of run
      opcode = HALT_OP; run = 1'b1;
      tick(); tick(); tick();
      check("halt_enter", 32'({state, halted}), 32'({4'd12, 1'b1}));
      for (int i = 0; i < 20; i++) begin
         run = 1'($urandom);
         opcode = 6'($urandom);
         tick();
         check("halt_hold", 32'({state, halted, dut_ctl}), 32'({4'd12, 1'b1, 13'd0}));
      end
      rst_n = 1'b0; #2 rst_n = 1'b1;

      // Randomized traffic
      halt_cycles = 0;
      for (int i = 0; i < 3000; i++) begin
         tick();
         run      = ($urandom_range(0, 9) != 0);
         alu_zero = 1'($urandom);
         r = $urandom_range(0, 19);
         if (r < 4)        opcode = {2'b00, 4'($urandom)};
         else if (r < 7)   opcode = {2'b01, 4'($urandom)};
         else if (r < 9)   opcode = 6'b100001;
         else if (r < 11)  opcode = 6'b100010;
         else if (r < 13)  opcode = 6'b110000;
         else if (r < 14)  opcode = 6'b110001;
         else if (r < 15)  opcode = 6'b111000;
         else if (r < 19)  opcode = 6'($urandom);
         else              opcode = ($urandom_range(0, 9) == 0) ? HALT_OP : 6'($urandom);
         halt_cycles = (m_mode == 2) ? halt_cycles + 1 : 0;
         if ($urandom_range(0, 199) == 0 || halt_cycles > 8) begin
            #2 rst_n = 1'b0;
            #1 rst_n = 1'b1;
            halt_cycles = 0;
         end
      end
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Moore/Mealy FSM that sequences the multicycle datapath through fetch, decode, execute, memory and write-back.
- Drives every datapath control line: IorD, RegWrite, RegDst, ALUSrcA/B, MemWrite, MemtoReg, BEQ, PCSrc, plus new PC-write and IR-write enables.
- Also tracks retired instructions, halt and illegal-opcode status.
- Sits beside the datapath. Takes the decoded opcode and the ALU equality flag; no data passes through it.

Parameters:
CNT_W, 16, width of retired-instruction counter
HALT_OP, 6'b111111, opcode that parks the FSM in HALT

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  reset, asynchronous, active-low
run  in  1  1 = fetch new instructions; 0 = finish current one, then idle
opcode  in  6  decoded OPcode from instruction decoder
alu_zero  in  1  ALU equality flag (BEQflag), valid in BRANCH
sel_ins  out  1  IorD select, 0 = PC
ir_write  out  1  latch instruction register
pc_write  out  1  update PC from PCSrc mux
pc_src  out  2  00 PC+1, 01 ALU result, 10 jump address, 11 latched ALUout
alu_src_a  out  1  0 = PC, 1 = reg A
alu_src_b  out  2  00 reg B, 01 constant 1, 10 sign-extended imm
reg_write  out  1  register-file write enable
reg_dst  out  1  0 = Rt, 1 = Rd
mem_to_reg  out  1  0 = ALU result, 1 = DMem data
mem_write  out  1  DMem write enable
beq_sel  out  1  0 = branch on equal, 1 = branch on not-equal
state  out  4  current state encoding (debug)
instr_count  out  CNT_W  retired instructions, wraps
halted  out  1  FSM in HALT
illegal  out  1  sticky: undefined opcode decoded

Behaviour:
- Reset (async, rst_n=0): state=IDLE, instr_count=0, halted=0, illegal=0. All control outputs 0.
- State encoding: IDLE 0, FETCH 1, DECODE 2, EXEC_R 3, WB_R 4, EXEC_I 5, WB_I 6, MEM_RD 7, LW_WB 8, MEM_WR 9, BRANCH 10, JUMP 11, HALT 12. Codes 13-15 go to IDLE next cycle.
- Opcode classes:
  - op[5:4]=00: R-type
  - op[5:4]=01: I-type ALU
  - 6'b100001: LW
  - 6'b100010: SW
  - 6'b110000: BEQ
  - 6'b110001: BNE
  - 6'b111000: J
  - HALT_OP: halt
  - anything else: illegal
- Controls are a function of state only; the one exception is pc_write in BRANCH. Any control not listed for a state is 0.
- IDLE: no controls asserted. Go to FETCH when run=1.
- FETCH: sel_ins=0, ir_write=1, alu_src_a=0, alu_src_b=01, pc_src=00, pc_write=1. Next state DECODE.
- DECODE: alu_src_a=0, alu_src_b=10, so branch target PC+imm is latched in ALUout. Branch on opcode class:
  - R-type → EXEC_R
  - I-type → EXEC_I
  - LW → MEM_RD
  - SW → MEM_WR
  - BEQ/BNE → BRANCH
  - J → JUMP
  - HALT_OP → HALT
  - illegal → set illegal, then FETCH if run else IDLE; not counted.
- EXEC_R: alu_src_a=1, alu_src_b=00. Next WB_R.
- WB_R: reg_dst=1, reg_write=1, mem_to_reg=0.
- EXEC_I: alu_src_a=1, alu_src_b=10. Next WB_I.
- WB_I: reg_dst=0, reg_write=1, mem_to_reg=0.
- MEM_RD: no controls asserted (DMem read). Next LW_WB.
- LW_WB: reg_dst=0, mem_to_reg=1, reg_write=1.
- MEM_WR: mem_write=1.
- BRANCH: alu_src_a=1, alu_src_b=00, beq_sel=opcode[0], pc_src=11. pc_write = alu_zero XOR beq_sel, evaluated combinationally.
- JUMP: pc_src=10, pc_write=1.
- Terminal states (WB_R, WB_I, LW_WB, MEM_WR, BRANCH, JUMP):
  - Retire: instr_count+1, wrapping from all-ones to 0.
  - Next state: FETCH if run=1, else IDLE.
- CPI: R/I/LW 4 cycles; SW/BEQ/BNE/J 3 cycles.
- HALT: halted=1, no controls asserted, HALT not counted. Leaves only via reset; run is ignored.
- run deassertion mid-instruction: the instruction always completes and retires. No new FETCH until run=1.
- illegal stays set until reset.
- Reset asserted mid-instruction: immediate return to IDLE with all outputs 0. No partial write-back or retire on that edge.

Test Plan:
- Reset then run=1, opcode=6'b000010 held → states 1,2,3,4 repeating. reg_write=1 and reg_dst=1 only in WB_R. instr_count=3 after 12 cycles.
- LW (6'b100001) then SW (6'b100010) → LW: mem_to_reg=1 and reg_write=1 on cycle 4 only. SW: mem_write=1 on cycle 3 only. instr_count=2 after 7 cycles.
- BEQ with alu_zero=1 → pc_src=11, pc_write=1 in BRANCH. BNE with alu_zero=1 → beq_sel=1, pc_write=0. Both retire.
- J (6'b111000) → pc_src=10, pc_write=1 in cycle 3. Then deassert run during JUMP → state IDLE next cycle with all controls 0. Reassert run → FETCH.
- Opcode 6'b101111 → illegal=1 after DECODE, count unchanged. Then HALT_OP → halted=1, state=12 held for 20 cycles regardless of run.
- Pull rst_n low during WB_R, asynchronously between edges → state=0 and reg_write=0 immediately, instr_count=0, illegal=0, halted=0.
